// File: rtl/pre_pa_serializer.sv
// Transmit serializer ahead of the PA driver: keys the PA, then sends a
// ramp, preamble, MSB-first data word and guard on a differential pair.
module pre_pa_serializer #(
    parameter int unsigned              WIDTH        = 8,
    parameter int unsigned              BIT_CYCLES   = 4,
    parameter int unsigned              RAMP_CYCLES  = 16,
    parameter int unsigned              PRE_LEN      = 4,
    parameter logic [PRE_LEN-1:0]       PRE_PATTERN  = 4'b1010,
    parameter int unsigned              GUARD_CYCLES = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InnerTransmit,
    input  logic             InnerValid,
    output logic             InnerReady,
    output logic             OuterTransmit,
    output logic             OuterTransmitN,
    output logic             PaEnable,
    output logic             Busy
);

    localparam int unsigned SYM_MAX = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
    localparam int unsigned RW = $clog2(RAMP_CYCLES + 1);
    localparam int unsigned BW = $clog2(BIT_CYCLES + 1);
    localparam int unsigned SW = $clog2(SYM_MAX + 1);
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

    localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BIT_CYCLES - 1);
    localparam logic [SW-1:0] PRE_LAST   = SW'(PRE_LEN - 1);
    localparam logic [SW-1:0] DATA_LAST  = SW'(WIDTH - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        PREAMBLE,
        DATA,
        GUARD
    } stateT;

    stateT              state;
    logic [RW-1:0]      rampCnt;
    logic [BW-1:0]      bitCnt;
    logic [SW-1:0]      symCnt;
    logic [GW-1:0]      guardCnt;
    // Both shift registers hold the symbols still to be sent; the bit on
    // the wire has already been moved into OuterTransmit.
    logic [PRE_LEN-1:0] preSr;
    logic [WIDTH-1:0]   dataSr;
    logic               lastDataClk;
    logic               transfer;

    // Final clock of the final data symbol: a new word may be taken here.
    assign lastDataClk = (state == DATA) && (bitCnt == BIT_LAST) && (symCnt == DATA_LAST);

    // Ready depends only on state/counters and is held low during reset.
    assign InnerReady = !Reset && ((state == IDLE) || (state == GUARD) || lastDataClk);
    assign transfer   = InnerValid && InnerReady;

    // Frame sequencer with registered line, PA and busy outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            rampCnt        <= '0;
            bitCnt         <= '0;
            symCnt         <= '0;
            guardCnt       <= '0;
            preSr          <= '0;
            dataSr         <= '0;
            OuterTransmit  <= 1'b0;
            OuterTransmitN <= 1'b0;
            PaEnable       <= 1'b0;
            Busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state          <= RAMP;
                        rampCnt        <= '0;
                        dataSr         <= InnerTransmit;
                        OuterTransmit  <= 1'b0;
                        OuterTransmitN <= 1'b1;
                        PaEnable       <= 1'b1;
                        Busy           <= 1'b1;
                    end
                end

                RAMP: begin
                    if (rampCnt == RAMP_LAST) begin
                        state          <= PREAMBLE;
                        bitCnt         <= '0;
                        symCnt         <= '0;
                        preSr          <= PRE_PATTERN << 1;
                        OuterTransmit  <= PRE_PATTERN[PRE_LEN-1];
                        OuterTransmitN <= ~PRE_PATTERN[PRE_LEN-1];
                    end else begin
                        rampCnt <= rampCnt + 1'b1;
                    end
                end

                PREAMBLE: begin
                    if (bitCnt != BIT_LAST) begin
                        bitCnt <= bitCnt + 1'b1;
                    end else if (symCnt == PRE_LAST) begin
                        state          <= DATA;
                        bitCnt         <= '0;
                        symCnt         <= '0;
                        dataSr         <= dataSr << 1;
                        OuterTransmit  <= dataSr[WIDTH-1];
                        OuterTransmitN <= ~dataSr[WIDTH-1];
                    end else begin
                        bitCnt         <= '0;
                        symCnt         <= symCnt + 1'b1;
                        preSr          <= preSr << 1;
                        OuterTransmit  <= preSr[PRE_LEN-1];
                        OuterTransmitN <= ~preSr[PRE_LEN-1];
                    end
                end

                DATA: begin
                    if (lastDataClk) begin
                        if (transfer) begin
                            // Back-to-back word: PA is warm, go straight to preamble.
                            state          <= PREAMBLE;
                            bitCnt         <= '0;
                            symCnt         <= '0;
                            dataSr         <= InnerTransmit;
                            preSr          <= PRE_PATTERN << 1;
                            OuterTransmit  <= PRE_PATTERN[PRE_LEN-1];
                            OuterTransmitN <= ~PRE_PATTERN[PRE_LEN-1];
                        end else begin
                            state          <= GUARD;
                            guardCnt       <= '0;
                            OuterTransmit  <= 1'b0;
                            OuterTransmitN <= 1'b1;
                        end
                    end else if (bitCnt != BIT_LAST) begin
                        bitCnt <= bitCnt + 1'b1;
                    end else begin
                        bitCnt         <= '0;
                        symCnt         <= symCnt + 1'b1;
                        dataSr         <= dataSr << 1;
                        OuterTransmit  <= dataSr[WIDTH-1];
                        OuterTransmitN <= ~dataSr[WIDTH-1];
                    end
                end

                GUARD: begin
                    if (transfer) begin
                        state          <= PREAMBLE;
                        bitCnt         <= '0;
                        symCnt         <= '0;
                        dataSr         <= InnerTransmit;
                        preSr          <= PRE_PATTERN << 1;
                        OuterTransmit  <= PRE_PATTERN[PRE_LEN-1];
                        OuterTransmitN <= ~PRE_PATTERN[PRE_LEN-1];
                    end else if (guardCnt == GUARD_LAST) begin
                        state          <= IDLE;
                        OuterTransmit  <= 1'b0;
                        OuterTransmitN <= 1'b0;
                        PaEnable       <= 1'b0;
                        Busy           <= 1'b0;
                    end else begin
                        guardCnt <= guardCnt + 1'b1;
                    end
                end

                default: begin
                    state          <= IDLE;
                    OuterTransmit  <= 1'b0;
                    OuterTransmitN <= 1'b0;
                    PaEnable       <= 1'b0;
                    Busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pre_pa_serializer.sv
// Directed bench for pre_pa_serializer: default build plus a minimal
// single-clock-per-phase build, checked clock by clock.
module tb_pre_pa_serializer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] innerTransmit;
    logic       innerValid;
    logic       innerReady;
    logic       outerTransmit;
    logic       outerTransmitN;
    logic       paEnable;
    logic       busy;

    logic [0:0] innerTransmit2;
    logic       innerValid2;
    logic       innerReady2;
    logic       outerTransmit2;
    logic       outerTransmitN2;
    logic       paEnable2;
    logic       busy2;

    int passes = 0;
    int checks = 0;
    int paCount;

    logic [4:0] vec;
    logic [4:0] vec2;
    logic [4:0] sweepExp [8];

    // {PaEnable, OuterTransmit, OuterTransmitN, Busy, InnerReady}
    assign vec  = {paEnable, outerTransmit, outerTransmitN, busy, innerReady};
    assign vec2 = {paEnable2, outerTransmit2, outerTransmitN2, busy2, innerReady2};

    always #5 Clock = ~Clock;

    pre_pa_serializer dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .InnerTransmit  (innerTransmit),
        .InnerValid     (innerValid),
        .InnerReady     (innerReady),
        .OuterTransmit  (outerTransmit),
        .OuterTransmitN (outerTransmitN),
        .PaEnable       (paEnable),
        .Busy           (busy)
    );

    pre_pa_serializer #(
        .WIDTH        (1),
        .BIT_CYCLES   (1),
        .RAMP_CYCLES  (1),
        .GUARD_CYCLES (1)
    ) dutSweep (
        .Clock          (Clock),
        .Reset          (Reset),
        .InnerTransmit  (innerTransmit2),
        .InnerValid     (innerValid2),
        .InnerReady     (innerReady2),
        .OuterTransmit  (outerTransmit2),
        .OuterTransmitN (outerTransmitN2),
        .PaEnable       (paEnable2),
        .Busy           (busy2)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Expected outputs for the default build at clock `pos` of a frame,
    // counted from the first RAMP clock: 16 ramp, 4x4 preamble, 8x4 data,
    // 8 guard, then idle.
    function automatic logic [4:0] expAt(input int pos, input logic [7:0] w);
        logic [3:0] pat;
        logic       b;
        int         idx;
        pat = 4'b1010;
        if (pos < 16) begin
            return 5'b10110;
        end else if (pos < 32) begin
            idx = 3 - (pos - 16) / 4;
            b   = pat[idx[1:0]];
            return {1'b1, b, ~b, 1'b1, 1'b0};
        end else if (pos < 64) begin
            idx = 7 - (pos - 32) / 4;
            b   = w[idx[2:0]];
            return {1'b1, b, ~b, 1'b1, (pos == 63)};
        end else if (pos < 72) begin
            return 5'b10111;
        end
        return 5'b00001;
    endfunction

    initial begin
        sweepExp[0] = 5'b10110;
        sweepExp[1] = 5'b11010;
        sweepExp[2] = 5'b10110;
        sweepExp[3] = 5'b11010;
        sweepExp[4] = 5'b10110;
        sweepExp[5] = 5'b11011;
        sweepExp[6] = 5'b10111;
        sweepExp[7] = 5'b00001;

        Reset          = 1'b1;
        innerValid     = 1'b0;
        innerTransmit  = 8'h00;
        innerValid2    = 1'b0;
        innerTransmit2 = 1'b0;

        // Reset and idle
        tick();
        tick();
        check("reset", vec, 5'b00000);
        check("resetSweep", vec2, 5'b00000);
        Reset = 1'b0;
        #1;
        check("releaseReady", vec, 5'b00001);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", vec, 5'b00001);
        end

        // Single word A5
        innerTransmit = 8'hA5;
        innerValid    = 1'b1;
        tick();
        innerValid    = 1'b0;
        innerTransmit = 8'h5A;
        paCount       = 0;
        for (int pos = 0; pos <= 72; pos++) begin
            check("single", vec, expAt(pos, 8'hA5));
            if (paEnable) paCount++;
            tick();
        end
        checkCount("singlePaClocks", paCount, 72);

        // Burst A5 then 3C, InnerValid held; word changes mid-frame
        innerTransmit = 8'hA5;
        innerValid    = 1'b1;
        tick();
        innerTransmit = 8'h3C;
        for (int pos = 0; pos <= 63; pos++) begin
            check("burst1", vec, expAt(pos, 8'hA5));
            if (pos < 63) tick();
        end
        tick();
        innerValid    = 1'b0;
        innerTransmit = 8'h00;
        for (int pos = 16; pos <= 72; pos++) begin
            check("burst2", vec, expAt(pos, 8'h3C));
            tick();
        end

        // Transfer at the third guard clock
        innerTransmit = 8'h96;
        innerValid    = 1'b1;
        tick();
        innerValid = 1'b0;
        for (int pos = 0; pos <= 65; pos++) begin
            check("guardFrame", vec, expAt(pos, 8'h96));
            tick();
        end
        check("guard3", vec, expAt(66, 8'h96));
        innerTransmit = 8'hFF;
        innerValid    = 1'b1;
        tick();
        innerValid = 1'b0;
        for (int pos = 16; pos <= 72; pos++) begin
            check("guardRestart", vec, expAt(pos, 8'hFF));
            tick();
        end

        // Reset mid-DATA, then a clean frame
        innerTransmit = 8'h81;
        innerValid    = 1'b1;
        tick();
        innerValid = 1'b0;
        for (int pos = 0; pos <= 40; pos++) begin
            check("preReset", vec, expAt(pos, 8'h81));
            if (pos < 40) tick();
        end
        Reset = 1'b1;
        tick();
        check("midReset", vec, 5'b00000);
        tick();
        check("midResetHold", vec, 5'b00000);
        Reset = 1'b0;
        #1;
        check("midResetRelease", vec, 5'b00001);
        innerTransmit = 8'h01;
        innerValid    = 1'b1;
        tick();
        innerValid = 1'b0;
        for (int pos = 0; pos <= 72; pos++) begin
            check("afterReset", vec, expAt(pos, 8'h01));
            tick();
        end

        // Minimal-parameter build, word 1
        innerTransmit2 = 1'b1;
        innerValid2    = 1'b1;
        tick();
        innerValid2 = 1'b0;
        paCount     = 0;
        for (int pos = 0; pos < 8; pos++) begin
            check("sweep", vec2, sweepExp[pos]);
            if (paEnable2) paCount++;
            tick();
        end
        checkCount("sweepPaClocks", paCount, 7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
